rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data width of each requester bus.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 4, legal range 1..255: maximum consecutive grant cycles while another requester waits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 4 bits: req[i] high means requester i wants the shared output.
REQ-006 The block SHALL have ports I0, I1, I2 and I3, each input, WIDTH bits: requester data buses.
REQ-007 The block SHALL have port gnt, output, 4 bits: registered one-hot grant, or all-zero when idle.
REQ-008 The block SHALL have port sel, output, 2 bits: registered index of the current owner; holds the last owner when idle.
REQ-009 The block SHALL have port led, output, WIDTH bits: registered shared output data.
REQ-010 The block SHALL have port led_valid, output, 1 bit: high when led carries granted data.

Function
REQ-011 The FSM SHALL have two states: IDLE (gnt = 0) and GRANT (exactly one gnt bit high).
REQ-012 In IDLE with any req bit high, the next edge SHALL enter GRANT and grant the first requesting index in the order sel+1, sel+2, sel+3, sel (mod 4).
REQ-013 In IDLE with req = 0, the FSM SHALL remain in IDLE and sel SHALL hold.
REQ-014 On entering GRANT, hold_cnt SHALL load 1; each further GRANT cycle SHALL increment it, saturating at HOLD_CYCLES.
REQ-015 In GRANT, if req[sel] = 0, the next edge SHALL enter IDLE, producing one dead cycle before any new grant.
REQ-016 In GRANT with req[sel] = 1, hold_cnt = HOLD_CYCLES and another req bit high, the next edge SHALL grant the next requester in round-robin order from sel, with no dead cycle, and reload hold_cnt to 1.
REQ-017 In GRANT with req[sel] = 1 and no other requester, the grant SHALL persist indefinitely.
REQ-018 When req[sel] drops and hold expiry occur on the same edge, the drop SHALL win and the FSM SHALL go to IDLE.
REQ-019 Each cycle, led SHALL register the bus selected by the current sel register (I0..I3), and led_valid SHALL register |gnt, so data lags gnt by one cycle.
REQ-020 When led_valid is low, led SHALL be all-zero.
REQ-021 Requester latency SHALL be: req high before edge N, gnt high after edge N, led/led_valid valid after edge N+1.

Reset
REQ-022 While rst = 1 at a clock edge, the block SHALL set state to IDLE, gnt to 0, sel to 2'd3 (so requester 0 has first priority), hold_cnt to 0, led to 0 and led_valid to 0.
REQ-023 Reset asserted mid-grant SHALL take effect at that edge and override every other transition.

Structure
REQ-024 A shared package/include SHALL hold NUM_REQ = 4, the state encodings IDLE and GRANT, and the default WIDTH.
REQ-025 The 4:1 WIDTH-bit data selection SHALL be a sub-module, mux4_bus (combinational, inputs sel and I0..I3), whose output is registered in rr_mux_arbiter.
REQ-026 The round-robin next-index search SHALL be a combinational function of (sel, req) inside the block.

Verification
REQ-027 Reset then req = 4'b0001, I0 = 8'hA5 -> gnt = 0001 after edge 1; led = A5 with led_valid = 1 after edge 2.
REQ-028 req = 4'b1111 held continuously, HOLD_CYCLES = 4 -> gnt rotates 0001, 0010, 0100, 1000, 0001, each exactly 4 cycles, with no dead cycles.
REQ-029 Requester 2 owns the grant, then drops req while req[3] = 1 -> one IDLE cycle with gnt = 0 and led_valid low, then gnt = 1000.
REQ-030 Only req[1] high for 20 cycles -> gnt = 0010 for all 20 cycles and hold_cnt saturates at 4.
REQ-031 rst pulsed during a grant to requester 3 -> next edge gnt = 0, led = 0, sel = 3; then req = 4'b1001 -> requester 0 granted first.
REQ-032 req[sel] drops on the same edge hold_cnt reaches HOLD_CYCLES with others pending -> IDLE for one cycle, then round-robin grant from the old sel.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin grant/data-steering block:
// requester count, FSM encodings and default bus width.
package rr_mux_arbiter_pkg;
    localparam int NUM_REQ       = 4;
    localparam int DEFAULT_WIDTH = 8;
    localparam int HOLD_W        = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_mux_arbiter_mux4_bus.sv
// Combinational 4:1 selector of WIDTH-bit requester buses; the caller
// registers the result.
module mux4_bus
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] bus [NUM_REQ];

    assign bus[0] = I0;
    assign bus[1] = I1;
    assign bus[2] = I2;
    assign bus[3] = I3;
    assign y      = bus[sel];
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for four requesters with a bounded hold time,
// steering the owner's bus onto a registered shared output one cycle later.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [WIDTH-1:0] I2,
    input  logic [WIDTH-1:0] I3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] led,
    output logic             led_valid
);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    state_t            state_reg, state_next;
    logic [1:0]        sel_reg, sel_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [3:0]        gnt_reg, gnt_next;
    logic [WIDTH-1:0]  led_reg, led_next;
    logic              led_valid_reg, led_valid_next;
    logic [WIDTH-1:0]  mux_y;
    logic              others_waiting;

    // First requester in the order cur+1, cur+2, cur+3, cur; lowest offset wins.
    function automatic logic [1:0] rr_next(input logic [1:0] cur, input logic [3:0] r);
        logic [1:0] idx;
        rr_next = cur;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (r[idx]) rr_next = idx;
        end
    endfunction

    mux4_bus #(.WIDTH(WIDTH)) u_mux (
        .sel (sel_reg),
        .I0  (I0),
        .I1  (I1),
        .I2  (I2),
        .I3  (I3),
        .y   (mux_y)
    );

    assign others_waiting = |(req & ~(4'(1) << sel_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sel_reg       <= 2'd3;
            hold_cnt_reg  <= '0;
            gnt_reg       <= '0;
            led_reg       <= '0;
            led_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            hold_cnt_reg  <= hold_cnt_next;
            gnt_reg       <= gnt_next;
            led_reg       <= led_next;
            led_valid_reg <= led_valid_next;
        end
    end

    // A dropped request always beats hold expiry, leaving one dead cycle.
    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next    = GRANT;
                    sel_next      = rr_next(sel_reg, req);
                    hold_cnt_next = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (!req[sel_reg]) begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg >= HOLD_MAX && others_waiting) begin
                    sel_next      = rr_next(sel_reg, req);
                    hold_cnt_next = HOLD_W'(1);
                end else if (hold_cnt_reg < HOLD_MAX) begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
            default: begin
                state_next    = IDLE;
                hold_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        gnt_next       = (state_next == GRANT) ? (4'(1) << sel_next) : 4'b0000;
        led_valid_next = |gnt_reg;
        led_next       = (|gnt_reg) ? mux_y : '0;
    end

    assign gnt       = gnt_reg;
    assign sel       = sel_reg;
    assign led       = led_reg;
    assign led_valid = led_valid_reg;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a per-cycle vector table plus a
// hand-written single-requester saturation sequence.
module tb_rr_mux_arbiter;
    localparam int WIDTH = 8;
    localparam int HOLD_CYCLES = 4;
    localparam int NV = 37;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [WIDTH-1:0] I0, I1, I2, I3;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] led;
    logic             led_valid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [7:0] led;
        logic       vld;
    } vec_t;

    vec_t vt [NV];

    rr_mux_arbiter #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .I0        (I0),
        .I1        (I1),
        .I2        (I2),
        .I3        (I3),
        .gnt       (gnt),
        .sel       (sel),
        .led       (led),
        .led_valid (led_valid)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g,
                                input logic [1:0] s, input logic [7:0] l, input logic v);
        vec_t t;
        t.rst = r; t.req = q; t.gnt = g; t.sel = s; t.led = l; t.vld = v;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000;
        I0 = 8'hA5; I1 = 8'h11; I2 = 8'h22; I3 = 8'h33;

        // Expected state after each edge: rst, req, gnt, sel, led, led_valid.
        vt[0]  = mk(1, 4'b0000, 4'b0000, 2'd3, 8'h00, 0);
        vt[1]  = mk(0, 4'b0001, 4'b0001, 2'd0, 8'h00, 0);
        vt[2]  = mk(0, 4'b0001, 4'b0001, 2'd0, 8'hA5, 1);
        vt[3]  = mk(0, 4'b0000, 4'b0000, 2'd0, 8'hA5, 1);
        vt[4]  = mk(0, 4'b0000, 4'b0000, 2'd0, 8'h00, 0);
        vt[5]  = mk(1, 4'b0000, 4'b0000, 2'd3, 8'h00, 0);
        vt[6]  = mk(0, 4'b1111, 4'b0001, 2'd0, 8'h00, 0);
        vt[7]  = mk(0, 4'b1111, 4'b0001, 2'd0, 8'hA5, 1);
        vt[8]  = mk(0, 4'b1111, 4'b0001, 2'd0, 8'hA5, 1);
        vt[9]  = mk(0, 4'b1111, 4'b0001, 2'd0, 8'hA5, 1);
        vt[10] = mk(0, 4'b1111, 4'b0010, 2'd1, 8'hA5, 1);
        vt[11] = mk(0, 4'b1111, 4'b0010, 2'd1, 8'h11, 1);
        vt[12] = mk(0, 4'b1111, 4'b0010, 2'd1, 8'h11, 1);
        vt[13] = mk(0, 4'b1111, 4'b0010, 2'd1, 8'h11, 1);
        vt[14] = mk(0, 4'b1111, 4'b0100, 2'd2, 8'h11, 1);
        vt[15] = mk(0, 4'b1111, 4'b0100, 2'd2, 8'h22, 1);
        vt[16] = mk(0, 4'b1111, 4'b0100, 2'd2, 8'h22, 1);
        vt[17] = mk(0, 4'b1111, 4'b0100, 2'd2, 8'h22, 1);
        vt[18] = mk(0, 4'b1111, 4'b1000, 2'd3, 8'h22, 1);
        vt[19] = mk(0, 4'b1111, 4'b1000, 2'd3, 8'h33, 1);
        vt[20] = mk(0, 4'b1111, 4'b1000, 2'd3, 8'h33, 1);
        vt[21] = mk(0, 4'b1111, 4'b1000, 2'd3, 8'h33, 1);
        vt[22] = mk(0, 4'b1111, 4'b0001, 2'd0, 8'h33, 1);
        vt[23] = mk(0, 4'b0100, 4'b0000, 2'd0, 8'hA5, 1);
        vt[24] = mk(0, 4'b0100, 4'b0100, 2'd2, 8'h00, 0);
        vt[25] = mk(0, 4'b1100, 4'b0100, 2'd2, 8'h22, 1);
        vt[26] = mk(0, 4'b1000, 4'b0000, 2'd2, 8'h22, 1);
        vt[27] = mk(0, 4'b1000, 4'b1000, 2'd3, 8'h00, 0);
        vt[28] = mk(0, 4'b1000, 4'b1000, 2'd3, 8'h33, 1);
        vt[29] = mk(1, 4'b1001, 4'b0000, 2'd3, 8'h00, 0);
        vt[30] = mk(0, 4'b1001, 4'b0001, 2'd0, 8'h00, 0);
        vt[31] = mk(0, 4'b1001, 4'b0001, 2'd0, 8'hA5, 1);
        vt[32] = mk(0, 4'b1001, 4'b0001, 2'd0, 8'hA5, 1);
        vt[33] = mk(0, 4'b1001, 4'b0001, 2'd0, 8'hA5, 1);
        vt[34] = mk(0, 4'b1000, 4'b0000, 2'd0, 8'hA5, 1);
        vt[35] = mk(0, 4'b1001, 4'b1000, 2'd3, 8'h00, 0);
        vt[36] = mk(0, 4'b1001, 4'b1000, 2'd3, 8'h33, 1);

        for (int i = 0; i < NV; i++) begin
            step(vt[i].rst, vt[i].req);
            $display("vec %0d rst=%0b req=%b gnt=%b sel=%0d led=%h vld=%0b",
                     i, vt[i].rst, vt[i].req, gnt, sel, led, led_valid);
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
            check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vt[i].sel));
            check($sformatf("vec%0d_led", i), 32'(led), 32'(vt[i].led));
            check($sformatf("vec%0d_vld", i), 32'(led_valid), 32'(vt[i].vld));
        end

        // Lone requester 1 for 20 cycles: grant persists, hold saturates,
        // and led follows a bus change one cycle later.
        step(1'b1, 4'b0000);
        check("solo_reset_gnt", 32'(gnt), 32'h0);
        for (int k = 1; k <= 20; k++) begin
            if (k == 11) I1 = 8'h5C;
            step(1'b0, 4'b0010);
            $display("solo %0d gnt=%b sel=%0d led=%h vld=%0b hold=%0d",
                     k, gnt, sel, led, led_valid, dut.hold_cnt_reg);
            check($sformatf("solo%0d_gnt", k), 32'(gnt), 32'h2);
            check($sformatf("solo%0d_hold", k), 32'(dut.hold_cnt_reg),
                  32'((k < HOLD_CYCLES) ? k : HOLD_CYCLES));
            check($sformatf("solo%0d_led", k), 32'(led),
                  32'((k == 1) ? 8'h00 : ((k >= 11) ? 8'h5C : 8'h11)));
            check($sformatf("solo%0d_vld", k), 32'(led_valid), 32'((k == 1) ? 0 : 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
